// File: rtl/csa_accumulator.sv
// Carry-save partial-product accumulator with iterative half-adder resolve.
// Latency: last row accepted in cycle T -> out_valid in cycle T+2+k (k = nonzero-carry resolve steps).
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
module csa_accumulator #(
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ACC_W-1:0] in_row,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_rows,
  output logic             busy
);

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    RESOLVE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t           state;
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] c;
  logic             ovf;
  logic [CNT_W-1:0] rows;

  logic [ACC_W-1:0] maj_v;
  logic [ACC_W-1:0] hc_v;
  logic             accept;

  // 3:2 compressor carries for accumulate, half-adder carries for resolve
  always_comb begin
    maj_v  = (s & c) | (s & in_row) | (c & in_row);
    hc_v   = s & c;
    accept = in_valid & in_ready;
  end

  // FSM plus datapath; handshake flags are registered alongside the state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      s         <= '0;
      c         <= '0;
      ovf       <= 1'b0;
      rows      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            s   <= s ^ c ^ in_row;
            // carry out of the top bit is dropped; it only sets the flag
            c   <= {maj_v[ACC_W-2:0], 1'b0};
            ovf <= ovf | maj_v[ACC_W-1];
            if (rows != {CNT_W{1'b1}}) begin
              rows <= rows + CNT_W'(1);
            end
            if (in_last) begin
              state    <= RESOLVE;
              in_ready <= 1'b0;
            end
          end
        end
        RESOLVE: begin
          if (c == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            s   <= s ^ c;
            c   <= {hc_v[ACC_W-2:0], 1'b0};
            ovf <= ovf | hc_v[ACC_W-1];
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= ACCUM;
            s         <= '0;
            c         <= '0;
            ovf       <= 1'b0;
            rows      <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACCUM;
          s         <= '0;
          c         <= '0;
          ovf       <= 1'b0;
          rows      <= '0;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign out_sum  = s;
  assign out_ovf  = ovf;
  assign out_rows = rows;
  assign busy     = (state != ACCUM) || (rows != '0);

endmodule
